button_event: RTL and testbench

- Sits directly downstream of the debouncer. Consumes its debounced level `DA` and converts it into single-cycle event pulses for the control FSMs.
- Events produced:
  - press
  - release
  - long-press
  - optional auto-repeat while held
- Replaces ad-hoc edge detection in consumers, so every button in the design uses one event model.

---
 rtl/button_event.sv | 170 +++++++++++++++++
 tb/tb_button_event.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
//  Module      : button_event
//  Description : Turns the debounced button level DA into single-cycle event
//                pulses (PRESS, RELEASE, LONG, optional auto-REPEAT) plus a
//                HELD level. Every button shares this one event model.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK      in   system clock, rising edge
//    RST      in   synchronous reset, active-high
//    DA       in   debounced button level, 1 = pressed
//    PRESS    out  one-cycle pulse on the rising edge of DA
//    RELEASE  out  one-cycle pulse on the falling edge of DA
//    LONG     out  one-cycle pulse after DA has been held HOLD_CYCLES cycles
//    REPEAT   out  one-cycle auto-repeat pulse every REPEAT_CYCLES in long hold
//    HELD     out  level, 1 while the state machine is not IDLE
//
//  Compile-time option
//    BUTTON_AUTOREPEAT_EN : when defined, REPEAT pulses during long hold.
//                           When undefined, REPEAT is tied to 0 and the
//                           counter rests at 0 in LONG_HOLD.
//
//  All outputs are registered; there is no combinational path from DA.
// ============================================================================
module button_event #(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CW            = 26
) (
    input  logic CLK,
    input  logic RST,
    input  logic DA,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG,
    output logic REPEAT,
    output logic HELD
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESSED   = 2'd1,
        S_LONG_HOLD = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_HOLD_LAST = CW'(HOLD_CYCLES - 1);

    // Elaboration-time guard on illegal parameter combinations.
    generate
        if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1 ||
            (longint'(HOLD_CYCLES) - 1) >= (longint'(1) << CW) ||
            (longint'(REPEAT_CYCLES) - 1) >= (longint'(1) << CW)) begin : g_bad_params
            $error("button_event: illegal HOLD_CYCLES/REPEAT_CYCLES/CW combination");
        end
    endgenerate

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          da_prev_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          repeat_q;
    logic          held_q;

    logic          rise;
    logic          fall;

    assign rise = DA & ~da_prev_q;
    assign fall = ~DA & da_prev_q;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CW-1:0] c_REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            // Capture the live level so a button held through reset does not
            // look like a fresh rising edge afterwards.
            da_prev_q <= DA;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            da_prev_q <= DA;
            // Pulses default low so each one lasts exactly one cycle.
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    // A fall here is only possible after a reset with the
                    // button held; it is deliberately ignored.
                    if (rise) begin
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                        state_q <= S_PRESSED;
                    end
                end

                S_PRESSED: begin
                    // Release has priority over reaching the hold threshold.
                    if (fall) begin
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_IDLE;
                    end else if (cnt_q == c_HOLD_LAST) begin
                        long_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_LONG_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_LONG_HOLD: begin
                    if (fall) begin
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_IDLE;
                    end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                        if (cnt_q == c_REPEAT_LAST) begin
                            repeat_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
`else
                        cnt_q <= '0;
`endif
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign PRESS   = press_q;
    assign RELEASE = release_q;
    assign LONG    = long_q;
    assign HELD    = held_q;

`ifdef BUTTON_AUTOREPEAT_EN
    assign REPEAT  = repeat_q;
`else
    // Register kept so the FSM body is identical in both builds; the port is
    // a constant 0 when auto-repeat is compiled out.
    logic unused_repeat;
    assign unused_repeat = repeat_q;
    assign REPEAT  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event
//  Description : Self-checking bench for button_event with HOLD_CYCLES=8,
//                REPEAT_CYCLES=4. A hand-written vector table covers the
//                short and back-to-back presses; longer sequences use a
//                time-since-press reference model feeding a scoreboard queue.
//                Honours BUTTON_AUTOREPEAT_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event;

    localparam int c_HOLD   = 8;
    localparam int c_REPEAT = 4;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit c_RPT_EN = 1'b1;
`else
    localparam bit c_RPT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r_rst = 1'b1;
    logic r_da  = 1'b0;
    logic w_press, w_release, w_long, w_repeat, w_held;

    button_event #(
        .HOLD_CYCLES  (c_HOLD),
        .REPEAT_CYCLES(c_REPEAT),
        .CW           (4)
    ) dut (
        .CLK    (clk),
        .RST    (r_rst),
        .DA     (r_da),
        .PRESS  (w_press),
        .RELEASE(w_release),
        .LONG   (w_long),
        .REPEAT (w_repeat),
        .HELD   (w_held)
    );

    // Expected output vector order: {PRESS, RELEASE, LONG, REPEAT, HELD}
    typedef struct {
        logic       rst;
        logic       da;
        logic [4:0] exp;
    } vec_t;

    vec_t       tbl[12];
    logic [4:0] sb_q[$];
    int         total = 0;
    int         bad   = 0;
    int         n_press, n_release, n_long, n_repeat;

    // Reference model: tracks edges elapsed since the PRESS edge.
    logic m_pressed = 1'b0;
    logic m_prev    = 1'b0;
    int   m_age     = 0;

    task automatic model_step(input logic r, input logic d, output logic [4:0] e);
        logic p, rl, lg, rp;
        p = 1'b0; rl = 1'b0; lg = 1'b0; rp = 1'b0;
        if (r) begin
            m_pressed = 1'b0;
            m_age     = 0;
        end else if (!m_pressed && d && !m_prev) begin
            p         = 1'b1;
            m_pressed = 1'b1;
            m_age     = 0;
        end else if (m_pressed && !d && m_prev) begin
            rl        = 1'b1;
            m_pressed = 1'b0;
        end else if (m_pressed) begin
            m_age = m_age + 1;
            lg    = (m_age == c_HOLD);
            rp    = c_RPT_EN && (m_age > c_HOLD) && (((m_age - c_HOLD) % c_REPEAT) == 0);
        end
        m_prev = d;
        e = {p, rl, lg, rp, (r ? 1'b0 : m_pressed)};
    endtask

    task automatic clear_counts();
        n_press = 0; n_release = 0; n_long = 0; n_repeat = 0;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic r, input logic d, input logic [4:0] e, input string nm);
        logic [4:0] got, want;
        r_rst = r;
        r_da  = d;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {w_press, w_release, w_long, w_repeat, w_held};
        want = sb_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b (PRESS,RELEASE,LONG,REPEAT,HELD) t=%0t", nm, got, want, $time);
        end
        total++;
        if ((int'(w_press) + int'(w_release) + int'(w_long)) > 1 || (w_repeat && (w_long || w_release))) begin
            bad++;
            $display("FAIL %s_exclusive: got=%b want=at most one event t=%0t", nm, got, $time);
        end
        n_press   += int'(w_press);
        n_release += int'(w_release);
        n_long    += int'(w_long);
        n_repeat  += int'(w_repeat);
    endtask

    task automatic mstep(input logic r, input logic d, input string nm);
        logic [4:0] e;
        model_step(r, d, e);
        step(r, d, e, nm);
    endtask

    task automatic check_cnt(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, got, want);
        end
    endtask

    initial begin
        // Short press (3 cycles high) then back-to-back single-cycle presses.
        tbl[0]  = '{1'b1, 1'b0, 5'b00000};
        tbl[1]  = '{1'b0, 1'b0, 5'b00000};
        tbl[2]  = '{1'b0, 1'b1, 5'b10001};
        tbl[3]  = '{1'b0, 1'b1, 5'b00001};
        tbl[4]  = '{1'b0, 1'b1, 5'b00001};
        tbl[5]  = '{1'b0, 1'b0, 5'b01000};
        tbl[6]  = '{1'b0, 1'b0, 5'b00000};
        tbl[7]  = '{1'b0, 1'b1, 5'b10001};
        tbl[8]  = '{1'b0, 1'b0, 5'b01000};
        tbl[9]  = '{1'b0, 1'b1, 5'b10001};
        tbl[10] = '{1'b0, 1'b0, 5'b01000};
        tbl[11] = '{1'b0, 1'b0, 5'b00000};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].da, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Long press: 20 cycles high.
        mstep(1'b1, 1'b0, "long_rst");
        clear_counts();
        for (int i = 0; i < 20; i++) mstep(1'b0, 1'b1, "long_hold");
        for (int i = 0; i < 3; i++)  mstep(1'b0, 1'b0, "long_rel");
        check_cnt("long_press_cnt",   n_press,   1);
        check_cnt("long_long_cnt",    n_long,    1);
        check_cnt("long_repeat_cnt",  n_repeat,  c_RPT_EN ? 2 : 0);
        check_cnt("long_release_cnt", n_release, 1);

        // Fall coincides with the hold threshold: release wins, no LONG.
        mstep(1'b1, 1'b0, "thr_rst");
        mstep(1'b0, 1'b0, "thr_idle");
        clear_counts();
        for (int i = 0; i < 8; i++) mstep(1'b0, 1'b1, "thr_hold");
        mstep(1'b0, 1'b0, "thr_fall");
        total++;
        if (!(w_release && !w_long && !w_held)) begin
            bad++;
            $display("FAIL thr_release_wins: got=%b%b%b want=100 (RELEASE,LONG,HELD)", w_release, w_long, w_held);
        end
        for (int i = 0; i < 4; i++) mstep(1'b0, 1'b0, "thr_after");
        check_cnt("thr_long_cnt",    n_long,    0);
        check_cnt("thr_release_cnt", n_release, 1);

        // Reset while in long hold with the button still down.
        mstep(1'b1, 1'b0, "mid_rst0");
        for (int i = 0; i < 12; i++) mstep(1'b0, 1'b1, "mid_hold");
        clear_counts();
        mstep(1'b1, 1'b1, "mid_rst");
        for (int i = 0; i < 5; i++) mstep(1'b0, 1'b1, "mid_still");
        for (int i = 0; i < 3; i++) mstep(1'b0, 1'b0, "mid_letgo");
        check_cnt("mid_no_release", n_release, 0);
        check_cnt("mid_no_press",   n_press,   0);
        mstep(1'b0, 1'b1, "mid_repress");
        mstep(1'b0, 1'b0, "mid_rel");
        mstep(1'b0, 1'b0, "mid_idle");
        check_cnt("mid_press_cnt",   n_press,   1);
        check_cnt("mid_release_cnt", n_release, 1);
        check_cnt("mid_long_cnt",    n_long,    0);

        // 30-cycle hold: repeats only when auto-repeat is compiled in.
        mstep(1'b1, 1'b0, "h30_rst");
        clear_counts();
        for (int i = 0; i < 30; i++) mstep(1'b0, 1'b1, "h30_hold");
        for (int i = 0; i < 2; i++)  mstep(1'b0, 1'b0, "h30_rel");
        check_cnt("h30_long_cnt",    n_long,    1);
        check_cnt("h30_repeat_cnt",  n_repeat,  c_RPT_EN ? 5 : 0);
        check_cnt("h30_release_cnt", n_release, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
